// File: rtl/rr_mux_sel_arbiter.sv
// rtl/rr_mux_sel_arbiter.sv - round-robin arbiter/sequencer for the shared 4:1 mux datapath
//
// Purpose: four requesters share one mux output. The arbiter picks a winner
// round-robin, drives the 2-bit select, waits GAP_CYCLES settle cycles, then
// asserts a one-hot grant bounded by MAX_HOLD cycles.
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   req      in   4  level requests, req[i] owns mux input i
//   done     in   1  owner release, only looked at while granted
//   gnt      out  4  one-hot grant or zero
//   sel      out  2  mux select {s1,s0}, current or pending owner
//   busy     out  1  high whenever not idle
//   timeout  out  1  one-cycle pulse on a hold-limit revocation

module rr_mux_sel_arbiter #(
   parameter int MAX_HOLD   = 16,
   parameter int GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       timeout
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   // A zero gap still needs a legal one-bit counter.
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETTLE, GRANT} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    wcur_q, wcur_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [3:0]    gnt_q, gnt_d;
   logic          timeout_q, timeout_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [GW-1:0] gap_q, gap_d;

   logic [1:0]    arb_ptr;
   logic [3:0]    arb_mask;
   logic          arb_start;
   logic [2:0]    win;
   logic          rel_hold;
   logic          rel_any;

   // Returns {found, index}: first set mask bit at ptr+1, ptr+2, ptr+3, ptr.
   // Iterating from the farthest slot down lets the nearest one win.
   function automatic logic [2:0] pick(input logic [1:0] p, input logic [3:0] m);
      logic [1:0] idx;
      logic [2:0] r;
      r = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = p + 2'(k);
         if (m[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sel_q     <= 2'd0;
         wcur_q    <= 2'd0;
         ptr_q     <= 2'd3;
         gnt_q     <= 4'd0;
         timeout_q <= 1'b0;
         hold_q    <= '0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         wcur_q    <= wcur_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         timeout_q <= timeout_d;
         hold_q    <= hold_d;
         gap_q     <= gap_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      wcur_d    = wcur_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      timeout_d = 1'b0;
      hold_d    = hold_q;
      gap_d     = gap_q;
      arb_ptr   = ptr_q;
      arb_mask  = req;
      arb_start = 1'b0;
      rel_hold  = (hold_q == HW'(MAX_HOLD - 1));
      rel_any   = done | ~req[wcur_q] | rel_hold;

      case (state_q)
         IDLE: begin
            arb_start = |req;
         end
         SETTLE: begin
            if (!req[wcur_q]) begin
               // Requester gave up before the grant: nothing served, ptr kept.
               state_d = IDLE;
            end else if (gap_q <= GW'(1)) begin
               gnt_d   = 4'b0001 << wcur_q;
               hold_d  = '0;
               state_d = GRANT;
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         GRANT: begin
            if (rel_any) begin
               gnt_d     = 4'd0;
               ptr_d     = wcur_q;
               state_d   = IDLE;
               // done has priority over the hold limit; a dropped request is
               // a voluntary release as well.
               timeout_d = rel_hold & ~done & req[wcur_q];
               // Handover: re-arbitrate behind the releasing owner. A timed-out
               // owner stays eligible so a sole requester gets re-granted.
               arb_ptr   = wcur_q;
               if (done || !req[wcur_q]) arb_mask = req & ~(4'b0001 << wcur_q);
               arb_start = 1'b1;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      win = pick(arb_ptr, arb_mask);
      if (arb_start && win[2]) begin
         sel_d  = win[1:0];
         wcur_d = win[1:0];
         if (GAP_CYCLES == 0) begin
            gnt_d   = 4'b0001 << win[1:0];
            hold_d  = '0;
            state_d = GRANT;
         end else begin
            gap_d   = GW'(GAP_CYCLES);
            state_d = SETTLE;
         end
      end
   end

   // Output logic
   always_comb begin
      gnt     = gnt_q;
      sel     = sel_q;
      busy    = (state_q != IDLE);
      timeout = timeout_q;
   end

endmodule

// File: doc/rr_mux_sel_arbiter.md
Name: rr_mux_sel_arbiter

Overview:
Round-robin arbiter and sequencer for the shared four-to-one CMOS mux datapath. Four requesters compete for the single mux output. The block drives the 2-bit select (sel[1] to s1, sel[0] to s0) and a one-hot grant. It inserts a programmable settle gap between a select change and the grant, and bounds every tenure with a hold-limit timeout.

Parameters:
- MAX_HOLD, 16, maximum cycles one grant may stay asserted; legal range >=1.
- GAP_CYCLES, 1, dead cycles between a sel update and the gnt assertion; legal range >=0.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  level requests; req[i] belongs to mux input i (0=a, 1=b, 2=c, 3=d).
- done  input  1  owner releases the mux; sampled only in GRANT.
- gnt  output  4  one-hot grant, or all zero.
- sel  output  2  mux select, {s1,s0}, index of the current or pending owner.
- busy  output  1  high whenever state is not IDLE.
- timeout  output  1  single-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset, asynchronous on rst_n low, immediate even mid-grant:
  - gnt=0, sel=0, busy=0, timeout=0, state=IDLE.
  - last-served pointer ptr=3, so requester 0 has highest priority first.
  - hold and gap counters cleared.
- Arbitration:
  - Winner = first i with req[i]=1, searching ptr+1, ptr+2, ptr+3, ptr in order, mod 4.
  - With a single requester, that requester always wins.
- IDLE:
  - If any req is high at an edge, sel<=winner and wcur<=winner on that edge.
  - If GAP_CYCLES>0, go to SETTLE with gap counter = GAP_CYCLES.
  - If GAP_CYCLES=0, go directly to GRANT and assert gnt on the same edge.
- SETTLE:
  - gnt=0; gap counter decrements each edge.
  - When it reaches 0: gnt[wcur]<=1, hold counter<=0, go to GRANT.
  - Request-to-grant latency is therefore 1+GAP_CYCLES edges from IDLE.
  - If req[wcur] drops during SETTLE: return to IDLE on the next edge, gnt never asserted, ptr unchanged.
- GRANT:
  - sel is stable and gnt[wcur]=1; hold counter increments every edge.
  - Release conditions, any one suffices:
    - done=1;
    - req[wcur]=0;
    - hold counter = MAX_HOLD-1, so gnt stays high exactly MAX_HOLD cycles.
  - On the release edge:
    - gnt<=0 and ptr<=wcur;
    - timeout<=1 only if the release was forced by the hold limit.
  - Back-to-back handover on the release edge:
    - Re-arbitrate on the same edge using the new ptr and current req, with wcur's req masked if done or req[wcur]=0.
    - If a winner exists, update sel and enter SETTLE (or GRANT with the new gnt if GAP_CYCLES=0); otherwise go to IDLE.
- Simultaneous events:
  - done together with the hold limit: treated as done, so timeout stays 0.
  - done while in IDLE or SETTLE: ignored.
  - A timed-out sole requester with req still high is re-granted after the gap, with timeout=1 on its release edge.
- Invariants:
  - gnt is never multi-hot.
  - sel never changes while gnt is non-zero, except during the GAP_CYCLES=0 handover edge.
- timeout is high for exactly one cycle per forced release.
- Counters are sized as clog2(MAX_HOLD+1) and clog2(GAP_CYCLES+1); they do not wrap.

Test Plan:
- Reset, then req=0100 held, done pulsed after 3 granted cycles (GAP=1) -> sel=2 at edge 1, gnt=0100 at edges 2-4, busy=1, gnt=0 and busy=0 after the done edge, timeout=0 throughout.
- req=1111 held, done pulsed on the 3rd cycle of every grant -> grant order 0001, 0010, 0100, 1000, 0001, each preceded by one gnt=0 settle cycle with sel already updated.
- req=0010 held, done never asserted, MAX_HOLD=16 -> gnt[1] high exactly 16 cycles, one timeout pulse, one gap cycle, then gnt=0010 again.
- req=1001 held, no done -> requester 0 times out after 16 cycles, requester 3 is granted next, then requester 0 again.
- req=0100 asserted, then dropped during SETTLE -> gnt stays 0000, return to IDLE; the next req=0101 grants requester 0 first because ptr is unchanged.
- Mid-grant gnt=0100, rst_n pulled low between edges -> gnt, sel, busy and timeout go to 0 without waiting for a clock; after release with req=1111, the first grant is 0001.
